// File: rtl/pipelined_adder_sub.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits split into STAGES
// ripple segments, carry registered between segments, valid/ready on both sides.
module pipelined_adder_sub #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("pipelined_adder_sub: WIDTH (%0d) must be at least 2", WIDTH);
  end
  if ((WIDTH % STAGES) != 0) begin : g_bad_stages
    $error("pipelined_adder_sub: STAGES (%0d) must divide WIDTH (%0d)", STAGES, WIDTH);
  end

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             c;     // carry out of the segment
    logic             cmsb;  // carry into the segment's top bit
  } seg_t;

  // Ripple one SEG-bit segment k of full-adder cells on top of the partial sum fs.
  function automatic seg_t seg_add(
    input int unsigned      k,
    input logic [WIDTH-1:0] fa,
    input logic [WIDTH-1:0] fb,
    input logic [WIDTH-1:0] fs,
    input logic             fc
  );
    seg_t r;
    logic ci;
    r.sum  = fs;
    r.c    = fc;
    r.cmsb = fc;
    for (int unsigned i = 0; i < SEG; i++) begin
      ci                = r.c;
      r.sum[k*SEG + i]  = fa[k*SEG + i] ^ fb[k*SEG + i] ^ ci;
      r.c               = ((fa[k*SEG + i] ^ fb[k*SEG + i]) & ci) |
                          (fa[k*SEG + i] & fb[k*SEG + i]);
      r.cmsb            = ci;
    end
    return r;
  endfunction

  logic                          adv;
  logic [WIDTH-1:0]              b_eff;
  logic                          c_eff;
  logic                          src_v;
  seg_t                          seg_r;

  logic [STAGES-1:0]             vld_q, vld_d;
  logic [STAGES-1:0]             cry_q, cry_d;
  logic [STAGES-1:0][WIDTH-1:0]  sum_q, sum_d;
  logic [STAGES-1:0][WIDTH-1:0]  opa_q, opa_d;
  logic [STAGES-1:0][WIDTH-1:0]  opb_q, opb_d;
  logic                          ovf_q, ovf_d;
  logic                          zero_q, zero_d;

  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | cin;

  always_comb begin
    adv    = ~vld_q[LAST] | out_ready;
    vld_d  = vld_q;
    cry_d  = cry_q;
    sum_d  = sum_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;

    src_v = in_valid;
    seg_r = seg_add(0, a, b_eff, '0, c_eff);
    if (adv) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        sum_d[0] = seg_r.sum;
        cry_d[0] = seg_r.c;
        opa_d[0] = a;
        opb_d[0] = b_eff;
      end
    end

    for (int unsigned k = 1; k < STAGES; k++) begin
      src_v = vld_q[k-1];
      seg_r = seg_add(k, opa_q[k-1], opb_q[k-1], sum_q[k-1], cry_q[k-1]);
      if (adv) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          sum_d[k] = seg_r.sum;
          cry_d[k] = seg_r.c;
          opa_d[k] = opa_q[k-1];
          opb_d[k] = opb_q[k-1];
        end
      end
    end

    // seg_r/src_v now describe the final segment (stage 0 when STAGES=1).
    if (adv && src_v) begin
      ovf_d  = seg_r.cmsb ^ seg_r.c;
      zero_d = ~|seg_r.sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      cry_q  <= '0;
      sum_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      cry_q  <= cry_d;
      sum_q  <= sum_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[LAST];
  assign s         = sum_q[LAST];
  assign cout      = cry_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Bench for pipelined_adder_sub: directed table on an 8/2 instance, hand-written
// stall/reset sequences, and a randomized 16/4 sweep against an arithmetic model.
module tb_pipelined_adder_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv8, ir8, ov8, ordy8, cin8, sub8, co8, ovf8, z8;
  logic [7:0] a8, b8, s8;

  logic        iv16, ir16, ov16, ordy16, cin16, sub16, co16, ovf16, z16;
  logic [15:0] a16, b16, s16;

  pipelined_adder_sub #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(ordy8), .s(s8),
    .cout(co8), .ovf(ovf8), .zero(z8));

  pipelined_adder_sub #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(ordy16), .s(s16),
    .cout(co16), .ovf(ovf16), .zero(z16));

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned n_out8 = 0;

  typedef struct { logic [15:0] s; logic co, ov, z; } res_t;
  res_t q8[$];
  res_t q16[$];

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] s;
    logic       co, ov, z;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic res_t model(input int unsigned w, input logic [15:0] ia,
                                 input logic [15:0] ib, input logic ic, input logic isb);
    res_t        r;
    logic [15:0] mask, bb;
    logic [16:0] full;
    mask = 16'((17'd1 << w) - 17'd1);
    bb   = isb ? (~ib & mask) : ib;
    full = 17'(ia) + 17'(bb) + 17'(isb ? 1'b1 : ic);
    r.s  = full[15:0] & mask;
    r.co = full[w];
    r.ov = (ia[w-1] == bb[w-1]) && (r.s[w-1] != ia[w-1]);
    r.z  = (r.s == 16'h0000);
    return r;
  endfunction

  function automatic logic [31:0] pkr(input res_t r);
    return 32'({r.z, r.ov, r.co, r.s});
  endfunction

  function automatic logic [31:0] pk8();
    return 32'({z8, ovf8, co8, 8'h00, s8});
  endfunction

  function automatic logic [31:0] pk16();
    return 32'({z16, ovf16, co16, s16});
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic step8(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic isb, input logic ordy,
                       output logic acc, output logic ir_o, output logic ov_o,
                       output logic [7:0] s_o);
    res_t r;
    @(negedge clk);
    iv8 = v; a8 = ia; b8 = ib; cin8 = ic; sub8 = isb; ordy8 = ordy;
    #1;
    ir_o = ir8; ov_o = ov8; s_o = s8;
    if (ov8) begin
      if (q8.size() == 0) check("dut8 unexpected out_valid", 32'(ov8), 0);
      else begin
        r = q8[0];
        check(ordy8 ? "dut8 result" : "dut8 held result", pk8(), pkr(r));
        if (ordy8) begin
          void'(q8.pop_front());
          n_out8++;
        end
      end
    end
    acc = iv8 && ir8;
    if (acc) q8.push_back(model(8, {8'h00, ia}, {8'h00, ib}, ic, isb));
    @(posedge clk);
  endtask

  task automatic step16(input logic v, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic isb, input logic ordy, output logic acc);
    res_t r;
    @(negedge clk);
    iv16 = v; a16 = ia; b16 = ib; cin16 = ic; sub16 = isb; ordy16 = ordy;
    #1;
    check("dut16 in_ready", 32'(ir16), 32'(!ov16 || ordy16));
    if (ov16) begin
      if (q16.size() == 0) check("dut16 unexpected out_valid", 32'(ov16), 0);
      else begin
        r = q16[0];
        check(ordy16 ? "dut16 result" : "dut16 held result", pk16(), pkr(r));
        if (ordy16) void'(q16.pop_front());
      end
    end
    acc = iv16 && ir16;
    if (acc) q16.push_back(model(16, ia, ib, ic, isb));
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[8];
    logic        acc, ir_s, ov_s, seen;
    logic [7:0]  s_s;
    int          p;
    int unsigned n0, k, acc_cnt;
    res_t        r;

    tbl[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'h35, 8'h35, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{8'h35, 8'h35, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    iv8 = 1'b0;  a8 = '0;  b8 = '0;  cin8 = 1'b0;  sub8 = 1'b0;  ordy8 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; ordy16 = 1'b1;

    // Reset state
    #2;
    check("reset s", 32'(s8), 0);
    check("reset cout", 32'(co8), 0);
    check("reset ovf", 32'(ovf8), 0);
    check("reset zero", 32'(z8), 0);
    check("reset out_valid", 32'(ov8), 0);
    check("reset in_ready", 32'(ir8), 1);
    ordy8 = 1'b0;
    #1;
    check("reset in_ready without out_ready", 32'(ir8), 1);
    check("reset dut16 out_valid", 32'(ov16), 0);
    ordy8 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Directed table, one operation at a time
    foreach (tbl[i]) begin
      @(negedge clk);
      iv8 = 1'b1; a8 = tbl[i].a; b8 = tbl[i].b; cin8 = tbl[i].cin; sub8 = tbl[i].sub;
      ordy8 = 1'b1;
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(ir8), 1);
      @(posedge clk);
      @(negedge clk);
      iv8 = 1'b0;
      #1;
      check($sformatf("vec%0d out_valid early", i), 32'(ov8), 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d out_valid at latency", i), 32'(ov8), 1);
      check($sformatf("vec%0d result", i), pk8(),
            32'({tbl[i].z, tbl[i].ov, tbl[i].co, 8'h00, tbl[i].s}));
    end
    @(posedge clk);

    // Backpressure: 1+1..4+4 with out_ready low in cycles 3-5
    p  = 1;
    n0 = n_out8;
    for (int cyc = 1; cyc <= 30 && !(p > 4 && q8.size() == 0); cyc++) begin
      step8(p <= 4, 8'(p), 8'(p), 1'b0, 1'b0, !(cyc >= 3 && cyc <= 5), acc, ir_s, ov_s, s_s);
      if (cyc >= 3 && cyc <= 5) begin
        check($sformatf("bp cycle%0d in_ready", cyc), 32'(ir_s), 0);
        check($sformatf("bp cycle%0d out_valid", cyc), 32'(ov_s), 1);
        check($sformatf("bp cycle%0d held s", cyc), 32'(s_s), 'h02);
      end
      if (acc) p++;
    end
    check("bp operands accepted", 32'(p), 5);
    check("bp results delivered", n_out8 - n0, 4);
    check("bp scoreboard empty", q8.size(), 0);

    // Reset with two operations in flight
    step8(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, acc, ir_s, ov_s, s_s);
    step8(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b1, acc, ir_s, ov_s, s_s);
    @(negedge clk);
    iv8 = 1'b0;
    #1;
    check("pre-reset out_valid", 32'(ov8), 1);
    rst_n = 1'b0;
    #1;
    check("mid-reset out_valid", 32'(ov8), 0);
    check("mid-reset s", 32'(s8), 0);
    q8.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step8(1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1'b1, acc, ir_s, ov_s, s_s);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, acc, ir_s, ov_s, s_s);
      if (ov_s) begin
        seen = 1'b1;
        check("post-reset first result", 32'(s_s), 'h30);
      end
    end
    check("post-reset result seen", 32'(seen), 1);

    // 16/4 latency and full carry chain across every segment
    @(negedge clk);
    iv16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1; sub16 = 1'b0; ordy16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    #1;
    k = 1;
    while (!ov16 && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("dut16 latency", k, 4);
    r = model(16, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    check("dut16 carry chain vs model", pk16(), pkr(r));
    check("dut16 carry chain", pk16(), 32'({1'b1, 1'b0, 1'b1, 16'h0000}));
    @(posedge clk);

    // Randomized sweep with random backpressure
    acc_cnt = 0;
    for (int cyc = 0; cyc < 60000 && acc_cnt < 10000; cyc++) begin
      step16($urandom_range(0, 3) != 0, pick16(), pick16(), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
      if (acc) acc_cnt++;
    end
    for (int i = 0; i < 50 && q16.size() != 0; i++)
      step16(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, acc);
    check("dut16 operations accepted", acc_cnt, 10000);
    check("dut16 drained", q16.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_sub.md
Name: pipelined_adder_sub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor.
- Generalises the single-bit full-adder cell to WIDTH bits, split into STAGES ripple segments with the carry registered between segments.
- Valid/ready handshake with backpressure on both sides.
- Flag outputs: carry, signed overflow and zero.
- Used as the arithmetic core of the next-generation ALU datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥2.
- STAGES, 2, number of pipeline stages; must divide WIDTH evenly; SEG = WIDTH/STAGES bits are added per stage.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set present on this cycle
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; used only when sub=0
- sub  input  1  0: A+B+cin; 1: A−B (A + ~B + 1)
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum/difference
- cout  output  1  carry out of MSB; for sub this is NOT-borrow
- ovf  output  1  signed overflow
- zero  output  1  s == 0

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low: while rst_n=0, every stage valid bit, s, cout, ovf, zero and out_valid are 0.
  - in_ready = 1 while in reset.
- Operand capture:
  - A transfer occurs when in_valid & in_ready.
  - At transfer, effective B' = sub ? ~b : b and effective carry c0 = sub ? 1 : cin.
  - Stage 0 registers A, B' and c0; the bit-level sum is the full-adder equations s_i = a_i^b_i^c_i, c_{i+1} = (a_i^b_i)&c_i | a_i&b_i.
- Pipeline:
  - Stage k (0..STAGES−1) adds bits [k*SEG +: SEG] with the carry from stage k−1.
  - Stage k registers the partial sum, the segment carry-out, and the still-unprocessed upper operand bits.
  - Lower result bits already computed travel forward unchanged.
- Latency:
  - Exactly STAGES cycles from transfer to out_valid when there is no backpressure.
  - Throughput: 1 result per cycle.
- Stall:
  - The pipeline advances when !out_valid | out_ready.
  - in_ready = !out_valid | out_ready; this is combinational and the whole pipe stalls together.
  - Bubbles (invalid stages) do not collapse during a stall.
- Hold while stalled:
  - While out_valid=1 and out_ready=0, s/cout/ovf/zero hold stable.
  - While stalled, a and b are ignored and no operand is lost.
- Flags:
  - Computed in the final stage and registered with s.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = ~|s.
  - Flags for results not yet valid are don't-care, but are 0 after reset.
- Ordering:
  - Results emerge in acceptance order.
  - No reordering and no drop.
- Simultaneous events:
  - Output consumed and new input accepted in the same cycle is legal and sustains full throughput.
- Reset mid-operation:
  - All in-flight operations are discarded.
  - out_valid falls asynchronously with rst_n.
  - The first valid output after reset release belongs to an operand accepted after release.
- Degenerate configuration:
  - STAGES=1 gives a single registered adder with 1-cycle latency.
  - A configuration where STAGES does not divide WIDTH is illegal; the implementation flags it with an elaboration-time check.

Test Plan:
- Reset check: WIDTH=8, STAGES=2; drive rst_n=0 → s=0, cout=0, ovf=0, zero=0, out_valid=0, in_ready=1.
- Add with carry: a=0x7F, b=0x01, cin=0, sub=0 → 2 cycles later s=0x80, cout=0, ovf=1, zero=0.
- Subtract to zero: a=0x35, b=0x35, sub=1 → s=0x00, cout=1, ovf=0, zero=1.
- Carry across the segment boundary: a=0xFF, b=0x00, cin=1 → s=0x00, cout=1, zero=1; confirms the carry crosses the stage boundary.
- Backpressure:
  - Stream 4 back-to-back adds (1+1, 2+2, 3+3, 4+4) with out_ready=0 for cycles 3–5.
  - Required: in_ready=0 during the stall, output held at 0x02, then 0x02, 0x04, 0x06, 0x08 in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 2 operations in flight → out_valid=0 immediately; after release, only newly accepted operands appear (e.g. 0x10+0x20 → 0x30).
- Parameter sweep: WIDTH=16, STAGES=4 with random operands and random out_ready → latency 4 when unstalled; s, cout and ovf match a reference model for ≥10k operations.
